zxunouart_bridge: RTL

- Parametrised ZX-UNO register-mapped UART bridge; successor to the single-FIFO RX/strobe-TX UART emulation.
- Buffers both directions: RX FIFO and TX FIFO with ready/valid drain to the UART core.
- Adds sticky overflow flags, TX-full status and hysteretic RX flow control.
- Sits between the ZX-UNO register bus decoder and the UART serialiser.

---
 rtl/zxunouart_bridge.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/zxunouart_bridge.sv
// rtl/zxunouart_bridge.sv - ZX-UNO register-mapped UART bridge with buffered RX and TX paths
//
// Purpose: decodes the UARTDATA/UARTSTAT registers of the ZX-UNO bus. It buffers received
// bytes in an RX FIFO and bus writes in a TX FIFO, and drives a hysteretic RTS-style flag.
// Ports:
//   clk_bus, reset_n             clock, async active-low reset
//   zxuno_addr/regrd/regwr/din   register bus access (levels)
//   dout, oe_n                   registered read data / active-low data valid
//   uart_tx_data/valid/ready     TX FIFO drain towards the UART serialiser
//   uart_rx_data/req             received byte strobe from the UART core
//   uart_rx_fifo_full            registered flow control, set at RX_HIWAT, released at RX_LOWAT
module zxunouart_bridge #(
  parameter logic [7:0] UARTDATA = 8'hC6,
  parameter logic [7:0] UARTSTAT = 8'hC7,
  parameter int         RX_AW    = 6,
  parameter int         TX_AW    = 4,
  parameter int         RX_HIWAT = 50,
  parameter int         RX_LOWAT = 16
) (
  input  logic       clk_bus,
  input  logic       reset_n,
  input  logic [7:0] zxuno_addr,
  input  logic       zxuno_regrd,
  input  logic       zxuno_regwr,
  input  logic [7:0] din,
  output logic [7:0] dout,
  output logic       oe_n,
  output logic [7:0] uart_tx_data,
  output logic       uart_tx_valid,
  input  logic       uart_tx_ready,
  input  logic [7:0] uart_rx_data,
  input  logic       uart_rx_req,
  output logic       uart_rx_fifo_full
);

  localparam logic [RX_AW:0] RX_DEPTH = {1'b1, {RX_AW{1'b0}}};
  localparam logic [TX_AW:0] TX_DEPTH = {1'b1, {TX_AW{1'b0}}};
  localparam logic [RX_AW:0] RX_HI    = (RX_AW+1)'(RX_HIWAT);
  localparam logic [RX_AW:0] RX_LO    = (RX_AW+1)'(RX_LOWAT);

  logic [7:0]       rx_mem_q [2**RX_AW];
  logic [RX_AW-1:0] rx_wptr_q, rx_rptr_q;
  logic [RX_AW:0]   rx_cnt_q, rx_cnt_d;
  logic [7:0]       tx_mem_q [2**TX_AW];
  logic [TX_AW-1:0] tx_wptr_q, tx_rptr_q;
  logic [TX_AW:0]   tx_cnt_q, tx_cnt_d;

  logic       regrd_q, regwr_q, rd_ok_q, wr_ok_q;
  logic [7:0] addr_q, dout_q, dout_d;
  logic       oe_n_q, oe_n_d;
  logic       rx_ovf_q, rx_ovf_d, tx_ovf_q, tx_ovf_d, fc_q, fc_d;

  logic rx_empty, rx_full, tx_empty, tx_full;
  logic rd_done, wr_start, stat_clr;
  logic rx_push, rx_pop, rx_ovf_set, tx_wr, tx_push, tx_pop, tx_ovf_set;
  logic [7:0] status;

  assign rx_empty = (rx_cnt_q == '0);
  assign rx_full  = (rx_cnt_q == RX_DEPTH);
  assign tx_empty = (tx_cnt_q == '0);
  assign tx_full  = (tx_cnt_q == TX_DEPTH);

  // rd_ok/wr_ok stay low after reset until the strobe has been seen low, so an access
  // that straddles reset release never produces a spurious edge.
  assign rd_done  = regrd_q & ~zxuno_regrd & rd_ok_q;
  assign wr_start = zxuno_regwr & ~regwr_q & wr_ok_q;
  assign stat_clr = rd_done & (addr_q == UARTSTAT);

  // A pop in the same cycle frees a slot in a full FIFO, so the push is still accepted.
  assign rx_pop     = rd_done & (addr_q == UARTDATA) & ~rx_empty;
  assign rx_push    = uart_rx_req & (~rx_full | rx_pop);
  assign rx_ovf_set = uart_rx_req & rx_full & ~rx_pop;

  assign tx_pop     = ~tx_empty & uart_tx_ready;
  assign tx_wr      = wr_start & (zxuno_addr == UARTDATA);
  assign tx_push    = tx_wr & (~tx_full | tx_pop);
  assign tx_ovf_set = tx_wr & tx_full & ~tx_pop;

  assign status = {~rx_empty, tx_full, rx_ovf_q, tx_empty, tx_ovf_q, 3'b000};

  assign uart_tx_valid     = ~tx_empty;
  assign uart_tx_data      = tx_mem_q[tx_rptr_q];
  assign dout              = dout_q;
  assign oe_n              = oe_n_q;
  assign uart_rx_fifo_full = fc_q;

  always_comb begin
    dout_d   = 8'hFF;
    oe_n_d   = 1'b1;
    rx_cnt_d = rx_cnt_q;
    tx_cnt_d = tx_cnt_q;
    fc_d     = fc_q;
    if (zxuno_regrd && zxuno_addr == UARTDATA) begin
      dout_d = rx_empty ? 8'h00 : rx_mem_q[rx_rptr_q];
      oe_n_d = 1'b0;
    end else if (zxuno_regrd && zxuno_addr == UARTSTAT) begin
      dout_d = status;
      oe_n_d = 1'b0;
    end
    if (rx_push && !rx_pop)      rx_cnt_d = rx_cnt_q + 1'b1;
    else if (rx_pop && !rx_push) rx_cnt_d = rx_cnt_q - 1'b1;
    if (tx_push && !tx_pop)      tx_cnt_d = tx_cnt_q + 1'b1;
    else if (tx_pop && !tx_push) tx_cnt_d = tx_cnt_q - 1'b1;
    if (rx_cnt_q >= RX_HI)      fc_d = 1'b1;
    else if (rx_cnt_q <= RX_LO) fc_d = 1'b0;
    // Setting beats clearing when both happen in the same cycle.
    rx_ovf_d = rx_ovf_set | (rx_ovf_q & ~stat_clr);
    tx_ovf_d = tx_ovf_set | (tx_ovf_q & ~stat_clr);
  end

  always_ff @(posedge clk_bus or negedge reset_n) begin
    if (!reset_n) begin
      rx_wptr_q <= '0;
      rx_rptr_q <= '0;
      rx_cnt_q  <= '0;
      tx_wptr_q <= '0;
      tx_rptr_q <= '0;
      tx_cnt_q  <= '0;
      regrd_q   <= 1'b0;
      regwr_q   <= 1'b0;
      rd_ok_q   <= 1'b0;
      wr_ok_q   <= 1'b0;
      addr_q    <= '0;
      dout_q    <= 8'hFF;
      oe_n_q    <= 1'b1;
      rx_ovf_q  <= 1'b0;
      tx_ovf_q  <= 1'b0;
      fc_q      <= 1'b0;
    end else begin
      if (rx_push) rx_wptr_q <= rx_wptr_q + 1'b1;
      if (rx_pop)  rx_rptr_q <= rx_rptr_q + 1'b1;
      if (tx_push) tx_wptr_q <= tx_wptr_q + 1'b1;
      if (tx_pop)  tx_rptr_q <= tx_rptr_q + 1'b1;
      rx_cnt_q <= rx_cnt_d;
      tx_cnt_q <= tx_cnt_d;
      regrd_q  <= zxuno_regrd;
      regwr_q  <= zxuno_regwr;
      rd_ok_q  <= rd_ok_q | ~zxuno_regrd;
      wr_ok_q  <= wr_ok_q | ~zxuno_regwr;
      if (zxuno_regrd) addr_q <= zxuno_addr;
      dout_q   <= dout_d;
      oe_n_q   <= oe_n_d;
      rx_ovf_q <= rx_ovf_d;
      tx_ovf_q <= tx_ovf_d;
      fc_q     <= fc_d;
    end
  end

  // FIFO storage carries no reset; occupancy counters decide what is valid.
  always_ff @(posedge clk_bus) begin
    if (rx_push) rx_mem_q[rx_wptr_q] <= uart_rx_data;
    if (tx_push) tx_mem_q[tx_wptr_q] <= din;
  end

endmodule
